// File: rtl/lp_rshift_requant_if.sv
// lp_rshift_requant_if: input/output beat streams of the requantizer
interface lp_rshift_requant_if #(
    parameter int IN_W = 32,
    parameter int OUT_W = 16,
    parameter int NUM_ELEM = 8
);
    logic in_valid;
    logic in_ready;
    logic [NUM_ELEM*IN_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic [NUM_ELEM*OUT_W-1:0] out_data;
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/lp_rshift_requant.sv
// lp_rshift_requant: per-matrix rounding right shift with signed saturation, two-stage elastic pipeline
module lp_rshift_requant #(
    parameter int IN_W = 32,
    parameter int OUT_W = 16,
    parameter int NUM_ELEM = 8,
    parameter int BEATS_PER_MAT = 64,
    parameter int SHIFT_W = $clog2(IN_W)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic clr_sat,
    output logic sat_flag,
    lp_rshift_requant_if.slave bus
);
    localparam int CNT_W = BEATS_PER_MAT > 1 ? $clog2(BEATS_PER_MAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_MAT - 1);
    localparam logic [SHIFT_W-1:0] MAX_SH = SHIFT_W'(IN_W - 1);
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

    logic [CNT_W-1:0] cnt;
    logic [SHIFT_W-1:0] shift_q, sh;
    logic [IN_W:0] rnd;
    logic signed [IN_W:0] v;
    logic [NUM_ELEM-1:0][IN_W:0] r_n, s1_r;
    logic [NUM_ELEM*OUT_W-1:0] sat_d, s2_d;
    logic s1_valid, s1_last, s2_valid, s2_last, s1_adv, accept, clip;

    assign s1_adv = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s1_adv;
    assign accept = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_last = s2_last;
    assign bus.out_data = s2_d;

    // the first beat of a matrix takes the live shift; later beats reuse the latched one
    always_comb begin
        r_n = '0;
        sh = cnt == '0 ? (cfg_shift > MAX_SH ? MAX_SH : cfg_shift) : shift_q;
        rnd = sh != '0 ? (IN_W+1)'(1) << (sh - 1'b1) : '0;
        for (int i = 0; i < NUM_ELEM; i++)
            r_n[i] = ($signed({bus.in_data[i*IN_W+IN_W-1], bus.in_data[i*IN_W +: IN_W]}) + $signed(rnd)) >>> sh;
    end

    always_comb begin
        clip = 1'b0;
        sat_d = '0;
        v = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            v = $signed(s1_r[i]);
            clip = clip | (v > MAX_V) | (v < MIN_V);
            sat_d[i*OUT_W +: OUT_W] = v > MAX_V ? MAX_V[OUT_W-1:0] : v < MIN_V ? MIN_V[OUT_W-1:0] : v[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            shift_q <= '0;
            s1_r <= '0;
            s1_valid <= 1'b0;
            s1_last <= 1'b0;
            s2_valid <= 1'b0;
            s2_last <= 1'b0;
            s2_d <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= cnt == LAST_CNT ? '0 : cnt + 1'b1;
                shift_q <= sh;
                s1_r <= r_n;
                s1_last <= cnt == LAST_CNT;
            end
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (s1_adv) begin
                s2_valid <= s1_valid;
                s2_last <= s1_valid && s1_last;
                if (s1_valid) s2_d <= sat_d;
            end
            if (s1_adv && s1_valid && clip) sat_flag <= 1'b1;
            else if (clr_sat) sat_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lp_rshift_requant.sv
// tb_lp_rshift_requant: directed + backpressure scoreboard bench for the requantizer
module tb_lp_rshift_requant;
    localparam int IN_W = 32;
    localparam int OUT_W = 16;
    localparam int NE = 8;
    localparam int BPM = 64;

    logic clk = 0, rst_n = 0, clr_sat = 0, sat_flag;
    logic [4:0] cfg_shift = '0;
    logic bp = 0, rnd_ready = 1, force_ready = 1, meas = 0;
    int chk = 0, err = 0, cyc = 0, occ = 0, tb_cnt = 0, tb_shift = 0;
    logic [128:0] q[$];
    int ac[$], oc[$];

    lp_rshift_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_ELEM(NE)) bus();

    lp_rshift_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_ELEM(NE), .BEATS_PER_MAT(BPM)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .clr_sat(clr_sat), .sat_flag(sat_flag), .bus(bus)
    );

    always #5 clk = ~clk;
    assign bus.out_ready = bp ? rnd_ready : force_ready;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end
    always @(posedge clk or negedge rst_n)
        if (!rst_n) occ <= 0;
        else occ <= occ + int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // floor((2x + 2^s) / 2^(s+1)) is round-half-up of x / 2^s
    function automatic logic [15:0] model(input logic [31:0] x, input int s);
        longint num, den, qv;
        num = 2 * longint'($signed(x)) + (longint'(1) << s);
        den = longint'(1) << (s + 1);
        qv = num / den;
        if (num < 0 && qv * den != num) qv--;
        if (qv > 32767) qv = 32767;
        if (qv < -32768) qv = -32768;
        return qv[15:0];
    endfunction

    task automatic send(input logic [255:0] x, input logic [4:0] sh, input logic [127:0] e, input bit use_model);
        int n;
        bus.in_valid = 1;
        bus.in_data = x;
        cfg_shift = sh;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk++;
        if (!bus.in_ready) begin
            err++;
            $display("FAIL accept_timeout: in_ready stuck at %b, required 1", bus.in_ready);
            @(posedge clk);
            #1;
            bus.in_valid = 0;
            return;
        end
        if (tb_cnt == 0) tb_shift = int'(sh);
        if (use_model) for (int i = 0; i < NE; i++) e[i*16 +: 16] = model(x[i*32 +: 32], tb_shift);
        q.push_back({e, tb_cnt == BPM - 1});
        if (meas) ac.push_back(cyc);
        tb_cnt = (tb_cnt + 1) % BPM;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
    endtask

    task automatic send_rep(input logic [31:0] x, input logic [4:0] sh, input logic [15:0] e);
        send({NE{x}}, sh, {NE{e}}, 0);
    endtask

    task automatic fill(input logic [4:0] sh);
        while (tb_cnt != 0) send_rep('0, sh, '0);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || occ != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            chk++;
            err++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", q.size());
        end
    endtask

    initial begin
        logic [255:0] v;
        bus.in_valid = 0;
        bus.in_data = '0;
        fork
            begin : mon
                logic [127:0] pd;
                logic pl;
                bit ps;
                logic [128:0] it;
                ps = 0;
                pd = '0;
                pl = 0;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (ps) begin
                            check("stall_data", bus.out_data, pd);
                            check("stall_valid_last", {bus.out_valid, bus.out_last}, {1'b1, pl});
                        end
                        check("in_ready", bus.in_ready, !(occ == 2 && !bus.out_ready));
                        if (bus.out_valid && bus.out_ready) begin
                            if (meas) oc.push_back(cyc);
                            if (q.size() == 0) begin
                                chk++;
                                err++;
                                $display("FAIL unexpected_output: got %h with no beat expected", bus.out_data);
                            end else begin
                                it = q.pop_front();
                                check("out_data", bus.out_data, it[128:1]);
                                check("out_last", bus.out_last, it[0]);
                            end
                        end
                    end
                    ps = rst_n && bus.out_valid && !bus.out_ready;
                    pd = bus.out_data;
                    pl = bus.out_last;
                end
            end
        join_none

        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);
        #19 rst_n = 1;
        @(posedge clk);
        #1;

        send_rep(32'h0000_1280, 5'd8, 16'h0013);
        send_rep(32'hFFFF_FE80, 5'd8, 16'hFFFF);
        send_rep(32'h0000_00FF, 5'd8, 16'h0001);
        fill(5'd8);
        drain();
        check("sat_after_round", sat_flag, 0);

        send_rep(32'h0100_0000, 5'd8, 16'h7FFF);
        fill(5'd8);
        drain();
        check("sat_after_clip", sat_flag, 1);
        clr_sat = 1;
        @(posedge clk);
        #1;
        clr_sat = 0;
        check("sat_after_clear", sat_flag, 0);

        // clr_sat is high exactly on the edge that loads the clipping beat into stage 2
        send_rep(32'h8000_0000, 5'd0, 16'h8000);
        clr_sat = 1;
        send_rep(32'h0000_1234, 5'd0, 16'h1234);
        clr_sat = 0;
        fill(5'd0);
        drain();
        check("sat_set_wins", sat_flag, 1);

        send_rep(32'h7FFF_FFFF, 5'd31, 16'h0001);
        fill(5'd31);
        drain();

        meas = 1;
        for (int i = 0; i < 3; i++) send_rep(32'h0000_1280, 5'd8, 16'h0013);
        for (int i = 3; i < BPM; i++) send_rep(32'h0000_1280, 5'd4, 16'h0013);
        for (int i = 0; i < BPM; i++) send_rep(32'h0000_1280, 5'd4, 16'h0128);
        drain();
        meas = 0;
        check("acc_count", ac.size(), 2 * BPM);
        check("out_count", oc.size(), 2 * BPM);
        if (ac.size() == 2 * BPM && oc.size() == 2 * BPM) begin
            check("latency", oc[0] - ac[0], 2);
            check("in_span", ac[2*BPM-1] - ac[0], 2 * BPM - 1);
            check("out_span", oc[2*BPM-1] - oc[0], 2 * BPM - 1);
        end

        bp = 1;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            for (int i = 0; i < NE; i++) v[i*32 +: 32] = 32'($signed($urandom) >>> $urandom_range(0, 24));
            send(v, 5'($urandom_range(0, 31)), '0, 1);
        end
        drain();
        bp = 0;

        fill(5'd8);
        send_rep(32'h8000_0000, 5'd0, 16'h8000);
        for (int i = 1; i < 20; i++) send_rep('0, 5'd0, '0);
        force_ready = 0;
        #2;
        check("pre_reset_valid", bus.out_valid, 1);
        check("pre_reset_sat", sat_flag, 1);
        rst_n = 0;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_last", bus.out_last, 0);
        check("async_rst_sat", sat_flag, 0);
        check("async_rst_in_ready", bus.in_ready, 1);
        q.delete();
        tb_cnt = 0;
        force_ready = 1;
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < BPM; i++) send_rep(32'(i << 8), 5'd8, 16'(i));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", chk, err);
        $finish;
    end
endmodule
